// File: rtl/pfb_32_demux_ctrl.sv
// Address/sequence controller for the 2x-oversampled PFB input commutator buffer.
// Define PFB_32_DEMUX_CTRL_STATUS_EN to add the issued/dropped frame status counters.
module pfb_32_demux_ctrl #(
    parameter int unsigned NUM_CHANNELS = 32,
    parameter int unsigned DECIMATION   = 16,
    parameter int unsigned BUF_DEPTH    = 64,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_PENDING  = 2
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic                            Input_valid,
    output logic                            Buf_wr_en,
    output logic [$clog2(BUF_DEPTH)-1:0]    Buf_wr_addr,
    output logic                            Buf_rd_en,
    output logic [$clog2(BUF_DEPTH)-1:0]    Buf_rd_addr,
    output logic                            Output_valid,
    output logic [$clog2(NUM_CHANNELS)-1:0] Output_channel,
    output logic                            Output_last,
`ifdef PFB_32_DEMUX_CTRL_STATUS_EN
    output logic [31:0]                     Status_frames_issued,
    output logic [15:0]                     Status_frames_dropped,
`endif
    output logic                            Error_overflow
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = $clog2(NUM_CHANNELS);
    localparam int unsigned DW = $clog2(DECIMATION);
    localparam int unsigned SW = AW - DW;
    localparam int unsigned PW = $clog2(MAX_PENDING + 1);

    localparam logic [CW-1:0] LastK      = CW'(NUM_CHANNELS - 1);
    localparam logic [CW-1:0] FirstReady = CW'(NUM_CHANNELS - 1);
    localparam logic [CW-1:0] NextReady  = CW'(DECIMATION - 1);
    localparam logic [PW-1:0] MaxPend    = PW'(MAX_PENDING);

    typedef enum logic [1:0] {StFill, StIdle, StRead} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] frame_base_q, frame_base_d;
    logic [CW-1:0] fill_cnt_q, fill_cnt_d;
    logic [CW-1:0] rd_k_q, rd_k_d;
    logic [PW-1:0] pending_q, pending_d;
    logic [SW-1:0] skip_q, skip_d;
    logic          ovf_q, ovf_d;

    logic          frame_ready;
    logic          burst_done;
    logic          drop;
    logic [SW-1:0] skip_inc;
    logic [AW-1:0] base_step;

    logic [READ_LATENCY-1:0]         vld_pipe_q, vld_pipe_d;
    logic [READ_LATENCY-1:0]         last_pipe_q, last_pipe_d;
    logic [READ_LATENCY-1:0][CW-1:0] chan_pipe_q, chan_pipe_d;

    assign Buf_wr_en   = Input_valid;
    assign Buf_wr_addr = wr_ptr_q;
    assign Buf_rd_en   = (state_q == StRead);
    assign Buf_rd_addr = frame_base_q + AW'(rd_k_q);

    assign burst_done  = (state_q == StRead) && (rd_k_q == LastK);
    assign frame_ready = Input_valid &&
                         (fill_cnt_q == ((state_q == StFill) ? FirstReady : NextReady));
    // A frame is dropped only if no burst retires in the same cycle to make room.
    assign drop        = frame_ready && (pending_q == MaxPend) && !burst_done;

    // Each dropped frame moves the next base one extra decimation step forward.
    assign skip_inc  = skip_q + SW'(1);
    assign base_step = {skip_inc, {DW{1'b0}}};

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        frame_base_d = frame_base_q;
        fill_cnt_d   = fill_cnt_q;
        rd_k_d       = rd_k_q;
        pending_d    = pending_q;
        skip_d       = skip_q;
        ovf_d        = ovf_q;

        if (Input_valid) begin
            wr_ptr_d   = wr_ptr_q + AW'(1);
            fill_cnt_d = frame_ready ? '0 : fill_cnt_q + CW'(1);
        end

        if (burst_done) begin
            frame_base_d = frame_base_q + base_step;
            skip_d       = '0;
        end
        if (drop) begin
            ovf_d  = 1'b1;
            skip_d = skip_inc;
        end

        if (frame_ready && !drop && !burst_done) begin
            pending_d = pending_q + PW'(1);
        end else if (burst_done && !frame_ready) begin
            pending_d = pending_q - PW'(1);
        end

        unique case (state_q)
            StFill: begin
                if (frame_ready) state_d = StIdle;
            end
            StIdle: begin
                if (pending_q != '0) begin
                    state_d = StRead;
                    rd_k_d  = '0;
                end
            end
            StRead: begin
                if (burst_done) begin
                    rd_k_d  = '0;
                    state_d = (pending_d != '0) ? StRead : StIdle;
                end else begin
                    rd_k_d = rd_k_q + CW'(1);
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        vld_pipe_d     = vld_pipe_q;
        last_pipe_d    = last_pipe_q;
        chan_pipe_d    = chan_pipe_q;
        vld_pipe_d[0]  = Buf_rd_en;
        last_pipe_d[0] = burst_done;
        chan_pipe_d[0] = Buf_rd_en ? (LastK - rd_k_q) : '0;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
            chan_pipe_d[i] = chan_pipe_q[i-1];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q      <= StFill;
            wr_ptr_q     <= '0;
            frame_base_q <= '0;
            fill_cnt_q   <= '0;
            rd_k_q       <= '0;
            pending_q    <= '0;
            skip_q       <= '0;
            ovf_q        <= 1'b0;
            vld_pipe_q   <= '0;
            last_pipe_q  <= '0;
            chan_pipe_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            frame_base_q <= frame_base_d;
            fill_cnt_q   <= fill_cnt_d;
            rd_k_q       <= rd_k_d;
            pending_q    <= pending_d;
            skip_q       <= skip_d;
            ovf_q        <= ovf_d;
            vld_pipe_q   <= vld_pipe_d;
            last_pipe_q  <= last_pipe_d;
            chan_pipe_q  <= chan_pipe_d;
        end
    end

    assign Output_valid   = vld_pipe_q[READ_LATENCY-1];
    assign Output_last    = last_pipe_q[READ_LATENCY-1];
    assign Output_channel = chan_pipe_q[READ_LATENCY-1];
    assign Error_overflow = ovf_q;

`ifdef PFB_32_DEMUX_CTRL_STATUS_EN
    logic [31:0] issued_q, issued_d;
    logic [15:0] dropped_q, dropped_d;

    always_comb begin
        issued_d  = issued_q;
        dropped_d = dropped_q;
        if (burst_done && (issued_q != '1)) issued_d = issued_q + 32'd1;
        if (drop && (dropped_q != '1)) dropped_d = dropped_q + 16'd1;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            issued_q  <= '0;
            dropped_q <= '0;
        end else begin
            issued_q  <= issued_d;
            dropped_q <= dropped_d;
        end
    end

    assign Status_frames_issued  = issued_q;
    assign Status_frames_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_pfb_32_demux_ctrl.sv
// Scoreboard bench for pfb_32_demux_ctrl: a timestamped frame-queue model predicts every output,
// a negedge monitor checks outputs against it and a shadow buffer checks the data addressing.
module tb_pfb_32_demux_ctrl;

    localparam int NCH   = 32;
    localparam int DEC   = 16;
    localparam int DEPTH = 64;
    localparam int RL    = 1;
    localparam int MAXP  = 2;

    logic       Clk         = 1'b0;
    logic       Rst_n       = 1'b0;
    logic       Input_valid = 1'b0;
    logic       Buf_wr_en, Buf_rd_en, Output_valid, Output_last, Error_overflow;
    logic [5:0] Buf_wr_addr, Buf_rd_addr;
    logic [4:0] Output_channel;
`ifdef PFB_32_DEMUX_CTRL_STATUS_EN
    logic [31:0] st_issued;
    logic [15:0] st_dropped;
`endif

    pfb_32_demux_ctrl #(
        .NUM_CHANNELS(NCH),
        .DECIMATION  (DEC),
        .BUF_DEPTH   (DEPTH),
        .READ_LATENCY(RL),
        .MAX_PENDING (MAXP)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Input_valid   (Input_valid),
        .Buf_wr_en     (Buf_wr_en),
        .Buf_wr_addr   (Buf_wr_addr),
        .Buf_rd_en     (Buf_rd_en),
        .Buf_rd_addr   (Buf_rd_addr),
        .Output_valid  (Output_valid),
        .Output_channel(Output_channel),
        .Output_last   (Output_last),
`ifdef PFB_32_DEMUX_CTRL_STATUS_EN
        .Status_frames_issued (st_issued),
        .Status_frames_dropped(st_dropped),
`endif
        .Error_overflow(Error_overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct { int cyc; int chan; int smp; } exp_t;
    typedef struct { int f; int start; } frm_t;

    exp_t sbq[$];
    frm_t fq[$];
    int   rdq[$];
    int   memm[DEPTH];

    int cyc       = 0;
    int n_acc     = 0;
    int last_comp = -1000;
    int issued_m  = 0;
    int dropped_m = 0;
    bit ovf_m     = 1'b0;
    bit rst_evt   = 1'b0;

    int checks  = 0;
    int errors  = 0;
    int outs    = 0;
    int rd_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame f becomes ready at edge r. A burst starts at the edge after the ready event when the
    // reader is free, or exactly when the previous burst retires; it lasts NCH cycles.
    task automatic frame_ready(input int r, input int f);
        int   live;
        frm_t fr;
        live = 0;
        foreach (fq[i]) if (fq[i].start + NCH > r) live++;
        if (live >= MAXP) begin
            // Queue full: the newest queued slot is redirected to the newest frame.
            ovf_m = 1'b1;
            dropped_m++;
            fr = fq[fq.size()-1];
            fr.f = f;
            fq[fq.size()-1] = fr;
        end else begin
            fr.f = f;
            fr.start = (r > last_comp) ? r + 1 : last_comp;
            fq.push_back(fr);
            last_comp = fr.start + NCH;
        end
    endtask

    task automatic push_burst(input frm_t fr);
        exp_t e;
        for (int k = 0; k < NCH; k++) begin
            e.cyc  = fr.start + k + RL;
            e.chan = NCH - 1 - k;
            e.smp  = DEC * fr.f + k;
            sbq.push_back(e);
        end
    endtask

    // Reference model: sees only bench-driven inputs at each rising edge.
    always @(posedge Clk) begin
        cyc++;
        if (!Rst_n) begin
            n_acc     = 0;
            last_comp = -1000;
            issued_m  = 0;
            dropped_m = 0;
            ovf_m     = 1'b0;
            rst_evt   = 1'b1;
            fq.delete();
            sbq.delete();
        end else begin
            foreach (fq[i]) if (fq[i].start + NCH == cyc) issued_m++;
            if (Input_valid) begin
                n_acc++;
                if (n_acc >= NCH && (n_acc % DEC) == 0) frame_ready(cyc, (n_acc - NCH) / DEC);
            end
            foreach (fq[i]) if (fq[i].start == cyc) push_burst(fq[i]);
            while (fq.size() > 0 && fq[0].start + NCH <= cyc) void'(fq.pop_front());
        end
    end

    // Monitor: samples DUT outputs mid-cycle, pops the scoreboard on every Output_valid.
    always @(negedge Clk) begin
        exp_t e;
        int   d;
        if (rst_evt) begin
            rst_evt = 1'b0;
            rdq.delete();
            foreach (memm[i]) memm[i] = -1;
            check("rd_en_after_reset", Buf_rd_en, 0);
            check("valid_after_reset", Output_valid, 0);
            check("channel_after_reset", Output_channel, 0);
            check("last_after_reset", Output_last, 0);
            check("wr_addr_after_reset", Buf_wr_addr, 0);
        end
        if (Output_valid) begin
            outs++;
            if (sbq.size() == 0) begin
                check("unexpected_output_valid", Output_valid, 0);
            end else begin
                e = sbq.pop_front();
                check("out_cycle", cyc, e.cyc);
                check("out_channel", Output_channel, e.chan);
                check("out_last", Output_last, (e.chan == 0) ? 1 : 0);
                if (rdq.size() > 0) d = rdq.pop_front();
                else d = -2;
                check("out_sample", d, e.smp);
            end
        end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            check("output_valid_missing", Output_valid, 1);
            void'(sbq.pop_front());
        end
        // Capture read data before this cycle's write lands in the shadow buffer.
        if (Buf_rd_en) begin
            rd_seen++;
            rdq.push_back(memm[Buf_rd_addr]);
        end
        check("buf_wr_en", Buf_wr_en, Input_valid);
        if (Input_valid) begin
            check("buf_wr_addr", Buf_wr_addr, n_acc % DEPTH);
            memm[Buf_wr_addr] = n_acc;
        end
        check("error_overflow", Error_overflow, ovf_m);
`ifdef PFB_32_DEMUX_CTRL_STATUS_EN
        check("frames_issued", st_issued, issued_m);
        check("frames_dropped", st_dropped, dropped_m);
`endif
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Input_valid = 1'b0;
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
    endtask

    task automatic send(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            Input_valid = 1'b1;
            tick();
            Input_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (sbq.size() == 0 && cyc > last_comp + RL + 1) break;
            tick();
        end
        check("scoreboard_drained", sbq.size(), 0);
    endtask

    initial begin
        int r0;
        int o0;
        do_reset();

        // First window: nothing until the 32nd sample, then one full burst.
        r0 = rd_seen;
        o0 = outs;
        send(31, 3);
        repeat (40) tick();
        check("no_read_before_32", rd_seen - r0, 0);
        send(1, 3);
        drain();
        check("first_burst_outputs", outs - o0, NCH);

        // Long stream at quarter rate.
        do_reset();
        o0 = outs;
        send(8192, 3);
        drain();
        check("quarter_rate_outputs", outs - o0, 2 * 8192 - NCH);

        // Half rate: back-to-back bursts, wrap 63->0, no overflow.
        do_reset();
        o0 = outs;
        send(4096, 1);
        drain();
        check("half_rate_outputs", outs - o0, 2 * 4096 - NCH);
        check("half_rate_no_overflow", Error_overflow, 0);

        // Full rate: frames must be dropped.
        do_reset();
        send(200, 0);
        drain();
        check("full_rate_overflow", Error_overflow, 1);
`ifdef PFB_32_DEMUX_CTRL_STATUS_EN
        check("dropped_nonzero", (st_dropped != 0) ? 1 : 0, 1);
`endif

        // Reset in the middle of a burst, then a fresh fill.
        do_reset();
        send(32, 1);
        for (int i = 0; i < 20 && !Buf_rd_en; i++) tick();
        check("burst_started", Buf_rd_en, 1);
        repeat (10) tick();
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        repeat (RL + 3) tick();
        r0 = rd_seen;
        o0 = outs;
        send(31, 1);
        repeat (40) tick();
        check("refill_no_read_before_32", rd_seen - r0, 0);
        send(1, 1);
        drain();
        check("refill_burst_outputs", outs - o0, NCH);

        // Random gaps, including stretches fast enough to drop frames.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            Input_valid = 1'b1;
            tick();
            Input_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
